flash_word_streamer: RTL

- Avalon-MM read master sitting directly upstream of the audio byte-slicing stage.
- Issues sequential 32-bit word reads to the flash controller, forward or reverse, within a bounded window [BASE, BASE+MAX_OFFSET] with wrap-around.
- Buffers returned words in a small show-ahead FIFO and hands them downstream over a valid/ready interface.
- Hides flash latency and waitrequest stalls from the consumer.

---
 rtl/flash_word_streamer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/flash_word_streamer.sv
// Avalon-MM read master streaming sequential flash words (forward or reverse, wrapping
// inside [BASE, BASE+MAX_OFFSET]) into a show-ahead FIFO with a valid/ready output.
module flash_word_streamer #(
  parameter int unsigned BASE       = 0,
  parameter int unsigned MAX_OFFSET = 16'h7FFF,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              fetch_clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              reverse,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [31:0]       word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy
);

  // state     | meaning
  // IDLE      | not streaming, FIFO empty
  // ISSUE     | read request on the bus, waiting for acceptance
  // WAIT_DATA | read accepted and awaiting data, or waiting for a free FIFO slot
  // DRAIN     | stopped with a read in flight; let it finish and drop its word

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(BASE + MAX_OFFSET);

  if (64'(BASE) + 64'(MAX_OFFSET) >= (64'd1 << ADDR_W)) begin : g_window_check
    $error("flash_word_streamer: BASE+MAX_OFFSET does not fit in ADDR_W bits");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("flash_word_streamer: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} state_t;

  state_t             state;
  logic               outstanding;
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               accept;
  logic               returned;
  logic               push;
  logic               pop;
  logic               flush;
  logic               room;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic rev);
    if (rev) return (a == ADDR_LO) ? ADDR_HI : a - ADDR_W'(1);
    else     return (a == ADDR_HI) ? ADDR_LO : a + ADDR_W'(1);
  endfunction

  assign accept     = flash_mem_read && !flash_mem_waitrequest;
  // Only data belonging to a read we issued counts; stale returns after reset are dropped.
  assign returned   = outstanding && flash_mem_readdatavalid;
  assign push       = (state == WAIT_DATA) && returned && !stop;
  assign pop        = word_valid && word_ready;
  assign flush      = stop && (state == ISSUE || state == WAIT_DATA);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign room       = count_next < CNT_W'(FIFO_DEPTH);

  assign word_valid = (count != '0);
  assign word_data  = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE);

  always_ff @(posedge fetch_clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= flash_mem_readdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge fetch_clock) begin
    if (!reset) begin
      state             <= IDLE;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= ADDR_LO;
      outstanding       <= 1'b0;
    end else begin
      if (accept)        outstanding <= 1'b1;
      else if (returned) outstanding <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state             <= ISSUE;
            flash_mem_read    <= 1'b1;
            flash_mem_address <= reverse ? ADDR_HI : ADDR_LO;
          end
        end
        ISSUE: begin
          if (stop) begin
            // A stalled request must stay on the bus until the slave takes it.
            if (flash_mem_waitrequest) begin
              state <= DRAIN;
            end else begin
              state          <= IDLE;
              flash_mem_read <= 1'b0;
            end
          end else if (!flash_mem_waitrequest) begin
            state          <= WAIT_DATA;
            flash_mem_read <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (stop) begin
            state <= (outstanding && !flash_mem_readdatavalid) ? DRAIN : IDLE;
          end else begin
            if (returned) flash_mem_address <= step_addr(flash_mem_address, reverse);
            if ((returned || !outstanding) && room) begin
              state          <= ISSUE;
              flash_mem_read <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept)        flash_mem_read <= 1'b0;
          else if (returned) state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
